// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 definitions: block width, CTR driver states and counter increment helper.
package sm4_encryptor_pkg;

  localparam int group_size_p    = 128;
  localparam int ctr_inc_width_p = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctr_state_e;

  // Only the low word counts; the upper bits are a fixed nonce and never see a carry.
  function automatic logic [group_size_p-1:0] ctr_inc(input logic [group_size_p-1:0] ctr);
    return {ctr[group_size_p-1:ctr_inc_width_p],
            ctr[ctr_inc_width_p-1:0] + {{(ctr_inc_width_p-1){1'b0}}, 1'b1}};
  endfunction

endpackage

// File: rtl/sm4_ctr_counter.sv
// CTR counter block register: loadable, with a wrapping increment of the low word.
module sm4_ctr_counter
  import sm4_encryptor_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic [group_size_p-1:0] load_val_i,
  input  logic                    inc_i,
  output logic [group_size_p-1:0] ctr_o
);

  logic [group_size_p-1:0] ctr_d;
  logic [group_size_p-1:0] ctr_q;

  // Next counter value: load wins over increment.
  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = load_val_i;
    end else if (inc_i) begin
      ctr_d = ctr_inc(ctr_q);
    end else begin
      ctr_d = ctr_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/sm4_ctr_driver.sv
// CTR-mode job driver for sm4_encryptor: issues counter blocks, retires keystream
// in order, XORs it with the data stream and presents results on a registered port.
module sm4_ctr_driver
  import sm4_encryptor_pkg::*;
#(
  parameter int max_outstanding_p = 2,
  parameter int blocks_width_p    = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      job_v_i,
  output logic                      job_ready_o,
  input  logic [group_size_p-1:0]   job_key_i,
  input  logic [group_size_p-1:0]   job_iv_i,
  input  logic [blocks_width_p-1:0] job_blocks_i,
  input  logic                      pt_v_i,
  input  logic [group_size_p-1:0]   pt_data_i,
  output logic                      pt_ready_o,
  output logic [group_size_p-1:0]   enc_content_o,
  output logic [group_size_p-1:0]   enc_key_o,
  output logic                      enc_decode_o,
  output logic                      enc_v_o,
  input  logic                      enc_ready_i,
  input  logic [group_size_p-1:0]   enc_crypt_i,
  input  logic                      enc_v_i,
  output logic                      enc_yumi_o,
  output logic                      out_v_o,
  output logic [group_size_p-1:0]   out_data_o,
  input  logic                      out_yumi_i,
  output logic                      done_o
);

  localparam int out_w_lp = $clog2(max_outstanding_p + 1);
  localparam logic [out_w_lp-1:0]       max_out_lp = out_w_lp'(max_outstanding_p);
  localparam logic [out_w_lp-1:0]       one_out_lp = out_w_lp'(1);
  localparam logic [blocks_width_p-1:0] one_blk_lp = blocks_width_p'(1);

  ctr_state_e                state_d, state_q;
  logic [group_size_p-1:0]   key_d, key_q;
  logic [blocks_width_p-1:0] issue_rem_d, issue_rem_q;
  logic [blocks_width_p-1:0] out_rem_d, out_rem_q;
  logic [out_w_lp-1:0]       outstanding_d, outstanding_q;
  logic                      out_v_d, out_v_q;
  logic [group_size_p-1:0]   out_data_d, out_data_q;

  logic                      ctr_load_s;
  logic                      issue_v_s;
  logic                      issue_fire_s;
  logic                      fire_s;
  logic                      out_take_s;
  logic [group_size_p-1:0]   ctr_s;

  sm4_ctr_counter u_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (ctr_load_s),
    .load_val_i (job_iv_i),
    .inc_i      (issue_fire_s),
    .ctr_o      (ctr_s)
  );

  assign out_take_s = out_v_q & out_yumi_i;

  // Job FSM: acceptance, issue/retire bookkeeping and completion.
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    issue_rem_d   = issue_rem_q;
    out_rem_d     = out_rem_q;
    outstanding_d = outstanding_q;
    ctr_load_s    = 1'b0;
    job_ready_o   = 1'b0;
    done_o        = 1'b0;
    issue_v_s     = 1'b0;
    issue_fire_s  = 1'b0;
    fire_s        = 1'b0;
    case (state_q)
      IDLE: begin
        job_ready_o = 1'b1;
        if (job_v_i) begin
          key_d       = job_key_i;
          ctr_load_s  = 1'b1;
          issue_rem_d = job_blocks_i;
          out_rem_d   = job_blocks_i;
          if (job_blocks_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Issue never looks at enc_ready_i, so there is no ready-to-valid path.
        issue_v_s    = (issue_rem_q != '0) && (outstanding_q < max_out_lp);
        issue_fire_s = issue_v_s & enc_ready_i;
        fire_s       = enc_v_i & pt_v_i & (~out_v_q | out_yumi_i);
        if (issue_fire_s) begin
          issue_rem_d = issue_rem_q - one_blk_lp;
        end else begin
          issue_rem_d = issue_rem_q;
        end
        case ({issue_fire_s, fire_s})
          2'b10:   outstanding_d = outstanding_q + one_out_lp;
          2'b01:   outstanding_d = outstanding_q - one_out_lp;
          default: outstanding_d = outstanding_q;
        endcase
        if (out_take_s) begin
          out_rem_d = out_rem_q - one_blk_lp;
          if (out_rem_q == one_blk_lp) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          out_rem_d = out_rem_q;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result register: a new fire reloads it even in the cycle the old result is taken.
  always_comb begin
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    if (fire_s) begin
      out_v_d    = 1'b1;
      out_data_d = pt_data_i ^ enc_crypt_i;
    end else if (out_take_s) begin
      out_v_d = 1'b0;
    end else begin
      out_v_d = out_v_q;
    end
  end

  // State, bookkeeping and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      key_q         <= '0;
      issue_rem_q   <= '0;
      out_rem_q     <= '0;
      outstanding_q <= '0;
      out_v_q       <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      issue_rem_q   <= issue_rem_d;
      out_rem_q     <= out_rem_d;
      outstanding_q <= outstanding_d;
      out_v_q       <= out_v_d;
      out_data_q    <= out_data_d;
    end
  end

  assign enc_v_o       = issue_v_s;
  assign enc_content_o = ctr_s;
  assign enc_key_o     = key_q;
  assign enc_decode_o  = 1'b0;
  assign enc_yumi_o    = fire_s;
  assign pt_ready_o    = fire_s;
  assign out_v_o       = out_v_q;
  assign out_data_o    = out_data_q;

endmodule

// File: tb/tb_sm4_ctr_driver.sv
// Self-checking bench for sm4_ctr_driver with a behavioural in-order SM4 encryptor.
module tb_sm4_ctr_driver;
  import sm4_encryptor_pkg::*;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         job_v_i = 1'b0;
  logic         job_ready_o;
  logic [127:0] job_key_i = '0;
  logic [127:0] job_iv_i = '0;
  logic [15:0]  job_blocks_i = '0;
  logic         pt_v_i = 1'b0;
  logic [127:0] pt_data_i = '0;
  logic         pt_ready_o;
  logic [127:0] enc_content_o;
  logic [127:0] enc_key_o;
  logic         enc_decode_o;
  logic         enc_v_o;
  logic         enc_ready_i = 1'b0;
  logic [127:0] enc_crypt_i = '0;
  logic         enc_v_i = 1'b0;
  logic         enc_yumi_o;
  logic         out_v_o;
  logic [127:0] out_data_o;
  logic         out_yumi_i = 1'b0;
  logic         done_o;

  sm4_ctr_driver #(.max_outstanding_p(2), .blocks_width_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .job_v_i(job_v_i), .job_ready_o(job_ready_o),
    .job_key_i(job_key_i), .job_iv_i(job_iv_i), .job_blocks_i(job_blocks_i),
    .pt_v_i(pt_v_i), .pt_data_i(pt_data_i), .pt_ready_o(pt_ready_o),
    .enc_content_o(enc_content_o), .enc_key_o(enc_key_o), .enc_decode_o(enc_decode_o),
    .enc_v_o(enc_v_o), .enc_ready_i(enc_ready_i), .enc_crypt_i(enc_crypt_i),
    .enc_v_i(enc_v_i), .enc_yumi_o(enc_yumi_o), .out_v_o(out_v_o), .out_data_o(out_data_o),
    .out_yumi_i(out_yumi_i), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] sbox_tbl [0:255] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sbox_tbl[a[31:24]], sbox_tbl[a[23:16]], sbox_tbl[a[15:8]], sbox_tbl[a[7:0]]};
  endfunction

  function automatic logic [127:0] sm4_enc(input logic [127:0] key, input logic [127:0] blk);
    logic [31:0] k [0:35];
    logic [31:0] x [0:35];
    logic [31:0] t;
    logic [31:0] ck;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
      t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
    end
    x[0] = blk[127:96]; x[1] = blk[95:64]; x[2] = blk[63:32]; x[3] = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
      x[i+4] = x[i] ^ t ^ rotl(t, 2) ^ rotl(t, 10) ^ rotl(t, 18) ^ rotl(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] ctr_add(input logic [127:0] iv, input int n);
    return {iv[127:32], iv[31:0] + 32'(n)};
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Model state: in-order encryptor keystream, data stream and expected results.
  logic [127:0] kq[$];
  logic [127:0] ptq[$];
  logic [127:0] expq[$];
  logic [127:0] got_q[$];
  logic [127:0] ctr_exp = '0;
  int  stall_left = 0, cyc = 0, issued = 0, outs = 0, dones = 0;
  int  done_cyc = -1, last_out_cyc = -1, accept_cyc = 0;
  bit  hold_prev = 1'b0, pt_rand = 1'b0, job_req = 1'b0, rst_req = 1'b1;
  logic [127:0] prev_data = '0;

  task automatic tick();
    @(negedge clk_i);
    cyc++;
    reset_i     = rst_req;
    job_v_i     = job_req;
    job_req     = 1'b0;
    enc_ready_i = ($urandom_range(0, 3) != 0);
    enc_v_i     = (kq.size() > 0) && ($urandom_range(0, 3) != 0);
    enc_crypt_i = (kq.size() > 0) ? kq[0] : 128'd0;
    pt_v_i      = (ptq.size() > 0) && (!pt_rand || ($urandom_range(0, 1) == 1));
    pt_data_i   = (ptq.size() > 0) ? ptq[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    out_yumi_i  = out_v_o && (stall_left == 0) && ($urandom_range(0, 2) != 0) && !rst_req;
    if (stall_left > 0) stall_left--;
    #1;
    if (reset_i) begin
      kq.delete(); ptq.delete(); expq.delete();
      hold_prev = 1'b0;
    end else begin
      if (job_v_i) begin
        check_val("job_accept_ready", job_ready_o, 1'b1);
        accept_cyc = cyc;
      end
      if (hold_prev) begin
        check_val("hold_v", out_v_o, 1'b1);
        check_val("hold_data", out_data_o, prev_data);
      end
      check_val("decode_zero", enc_decode_o, 1'b0);
      check_val("pt_ready_eq_yumi", pt_ready_o, enc_yumi_o);
      if (enc_yumi_o) begin
        check_val("fire_legal", {enc_v_i, pt_v_i}, 2'b11);
        if (kq.size() > 0) void'(kq.pop_front());
        if (ptq.size() > 0) void'(ptq.pop_front());
      end
      if (enc_v_o && enc_ready_i) begin
        check_val("ctr_seq", enc_content_o, ctr_exp);
        kq.push_back(sm4_enc(enc_key_o, enc_content_o));
        ctr_exp = ctr_add(ctr_exp, 1);
        issued++;
        check_val("outstanding_le2", kq.size() <= 2, 1'b1);
      end
      if (out_v_o && out_yumi_i) begin
        if (expq.size() == 0) check_val("unexpected_out", 1'b1, 1'b0);
        else check_val("out_data", out_data_o, expq.pop_front());
        got_q.push_back(out_data_o);
        outs++;
        last_out_cyc = cyc;
      end
      if (done_o) begin
        dones++;
        done_cyc = cyc;
      end
      hold_prev = out_v_o && !out_yumi_i;
      prev_data = out_data_o;
    end
  endtask

  task automatic start_job(input logic [127:0] key, input logic [127:0] iv, input int n,
                           input logic [127:0] pts[$], input logic [127:0] exps[$],
                           input int stall, input bit prand);
    job_key_i = key; job_iv_i = iv; job_blocks_i = 16'(n);
    ctr_exp = iv; issued = 0; outs = 0; dones = 0; done_cyc = -1; last_out_cyc = -1;
    got_q.delete();
    foreach (pts[i]) ptq.push_back(pts[i]);
    foreach (exps[i]) expq.push_back(exps[i]);
    pt_rand = prand; stall_left = stall; job_req = 1'b1;
    tick();
  endtask

  task automatic run_job(input logic [127:0] key, input logic [127:0] iv, input int n,
                         input logic [127:0] pts[$], input logic [127:0] exps[$],
                         input int stall, input bit prand);
    int budget;
    start_job(key, iv, n, pts, exps, stall, prand);
    budget = 0;
    while (dones == 0 && budget < 3000) begin
      tick();
      budget++;
    end
    if (dones == 0) check_val("timeout_done", 1'b0, 1'b1);
    check_val("issued_count", issued, n);
    check_val("out_count", outs, n);
    check_val("done_timing", done_cyc, ((n == 0) ? accept_cyc : last_out_cyc) + 1);
    tick();
    check_val("ready_after_done", job_ready_o, 1'b1);
    check_val("done_single_pulse", done_o, 1'b0);
  endtask

  initial begin : main
    logic [127:0] pts[$];
    logic [127:0] exps[$];
    logic [127:0] orig[$];
    logic [127:0] key, iv, r;
    int budget;

    // Reset state
    tick(); tick();
    check_val("rst_job_ready", job_ready_o, 1'b1);
    check_val("rst_enc_v", enc_v_o, 1'b0);
    check_val("rst_enc_yumi", enc_yumi_o, 1'b0);
    check_val("rst_pt_ready", pt_ready_o, 1'b0);
    check_val("rst_out_v", out_v_o, 1'b0);
    check_val("rst_out_data", out_data_o, 128'd0);
    check_val("rst_done", done_o, 1'b0);
    rst_req = 1'b0;
    tick();

    // Single-block known-answer
    key = 128'h0123456789abcdeffedcba9876543210;
    pts = {128'd0};
    exps = {128'h681edf34d206965e86b3e94f536e4246};
    run_job(key, key, 1, pts, exps, 0, 1'b0);

    // Counter low-word wrap
    iv = {$urandom(), $urandom(), 32'h00000000, 32'hFFFFFFFE};
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    pts.delete(); exps.delete();
    for (int i = 0; i < 3; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      pts.push_back(r);
      exps.push_back(r ^ sm4_enc(key, ctr_add(iv, i)));
    end
    run_job(key, iv, 3, pts, exps, 0, 1'b1);

    // Zero-length job
    pts.delete(); exps.delete();
    run_job(key, iv, 0, pts, exps, 0, 1'b0);

    // Backpressure: results held for 20 cycles, random data valid
    iv = {$urandom(), $urandom(), $urandom(), $urandom()};
    pts.delete(); exps.delete();
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      pts.push_back(r);
      exps.push_back(r ^ sm4_enc(key, ctr_add(iv, i)));
    end
    run_job(key, iv, 8, pts, exps, 20, 1'b1);

    // Round trip: encrypt, then run the results back through the same key/iv
    iv = {$urandom(), $urandom(), $urandom(), $urandom()};
    pts.delete(); exps.delete(); orig.delete();
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      orig.push_back(r);
      exps.push_back(r ^ sm4_enc(key, ctr_add(iv, i)));
    end
    run_job(key, iv, 4, orig, exps, 0, 1'b1);
    pts = got_q;
    run_job(key, iv, 4, pts, orig, 0, 1'b1);

    // Reset after two of five results
    iv = {$urandom(), $urandom(), $urandom(), $urandom()};
    pts.delete(); exps.delete();
    for (int i = 0; i < 5; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      pts.push_back(r);
      exps.push_back(r ^ sm4_enc(key, ctr_add(iv, i)));
    end
    start_job(key, iv, 5, pts, exps, 0, 1'b0);
    budget = 0;
    while (outs < 2 && budget < 3000) begin
      tick();
      budget++;
    end
    check_val("mid_outs_reached", outs, 2);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    dones = 0;
    tick();
    check_val("mid_rst_ready", job_ready_o, 1'b1);
    check_val("mid_rst_out_v", out_v_o, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_val("mid_rst_no_done", dones, 0);
    pts.delete(); exps.delete();
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    pts.push_back(r);
    exps.push_back(r ^ sm4_enc(key, iv));
    run_job(key, iv, 1, pts, exps, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sm4_ctr_driver.md
Name: sm4_ctr_driver

Overview:
Initiator-side companion to sm4_encryptor. It turns a CTR-mode job into a stream of counter blocks and issues them through the encryptor's v/ready input handshake. It takes back keystream blocks through the encryptor's v/yumi output handshake. Each keystream block is XORed with a plaintext (or ciphertext) stream, and the result goes out on a registered v/yumi port. CTR uses encryption in both directions, so the driver never requests decode.

Parameters:
max_outstanding_p, 2, maximum counter blocks accepted by the encryptor but not yet retired (1..7)
blocks_width_p, 16, width of the job block count

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
job_v_i  in  1  job request valid
job_ready_o  out  1  driver idle, can accept a job
job_key_i  in  group_size_p  SM4 key
job_iv_i  in  group_size_p  initial counter block
job_blocks_i  in  blocks_width_p  number of 128-bit blocks in the job
pt_v_i  in  1  input data block valid
pt_data_i  in  group_size_p  input data block
pt_ready_o  out  1  input data block consumed this cycle
enc_content_o  out  group_size_p  counter block to encryptor content_i
enc_key_o  out  group_size_p  key to encryptor key_i
enc_decode_o  out  1  to encryptor encode_or_decode_i; constant 0
enc_v_o  out  1  to encryptor v_i
enc_ready_i  in  1  from encryptor ready_o
enc_crypt_i  in  group_size_p  from encryptor crypt_o (keystream)
enc_v_i  in  1  from encryptor v_o
enc_yumi_o  out  1  to encryptor yumi_i
out_v_o  out  1  result block valid
out_data_o  out  group_size_p  result block
out_yumi_i  in  1  result consumed
done_o  out  1  one-cycle pulse when a job completes

Behaviour:
- Reset: state IDLE; all counters, key and counter registers cleared.
  - Output values after reset: job_ready_o=1, enc_v_o=0, enc_yumi_o=0, pt_ready_o=0, out_v_o=0, out_data_o=0, done_o=0.
  - Reset mid-job abandons the job. No result or done_o is emitted. The encryptor shares reset_i.
- States: IDLE, RUN, DONE.
- IDLE:
  - job_ready_o=1.
  - On job_v_i, latch key, ctr_r=job_iv_i, issue_rem_r=out_rem_r=job_blocks_i.
  - job_blocks_i==0 goes to DONE. Otherwise go to RUN.
- RUN, issue side:
  - enc_v_o = (issue_rem_r!=0) & (outstanding_r<max_outstanding_p).
  - enc_content_o=ctr_r, enc_key_o=key_r.
  - On enc_v_o&enc_ready_i: ctr_r[31:0] increments modulo 2^32 and ctr_r[127:32] is unchanged. Example: ...FFFFFFFF goes to ...00000000 with no carry into bit 32. issue_rem_r decrements and outstanding_r increments.
  - enc_v_o does not depend on enc_ready_i (no combinational path).
- RUN, retire side:
  - fire = enc_v_i & pt_v_i & (~out_v_o | out_yumi_i).
  - enc_yumi_o = pt_ready_o = fire.
  - On fire, out_data_o <= pt_data_i ^ enc_crypt_i next cycle, out_v_o <= 1, and outstanding_r decrements.
  - Issue and fire in the same cycle leave outstanding_r unchanged.
  - Keystream blocks return in issue order. The encryptor is in-order.
- Output port:
  - Registered. Latency is 1 cycle from fire to out_v_o.
  - out_v_o stays asserted and out_data_o stable until out_yumi_i.
  - A back-to-back fire in the out_yumi_i cycle gives full throughput.
- Completion:
  - Each out_yumi_i decrements out_rem_r.
  - When out_yumi_i takes out_rem_r from 1 to 0, next state is DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. job_ready_o=0 in RUN and DONE.
- Outside RUN: pt_ready_o=0, enc_yumi_o=0, enc_v_o=0. pt_v_i and enc_v_i are ignored.
- enc_decode_o is tied to 0.
- Protocol errors, flagged by bench assertions:
  - out_yumi_i without out_v_o.
  - enc_v_i with outstanding_r==0.
- outstanding_r width is $clog2(max_outstanding_p+1).

Decomposition:
- group_size_p comes from sm4_encryptor_pkg.
- Add to sm4_encryptor_pkg: typedef ctr_state_e {IDLE, RUN, DONE} and localparam ctr_inc_width_p=32.
- Sub-module sm4_ctr_counter: a 128-bit register with a 32-bit wrapping increment and load. Everything else stays flat.

Test Plan:
- Single-block KAT:
  - Stimulus: key=0123456789abcdeffedcba9876543210, iv=0123456789abcdeffedcba9876543210, blocks=1, pt=0, driving a real sm4_encryptor.
  - Required response: out_data_o=681edf34d206965e86b3e94f536e4246, then done_o one cycle after out_yumi_i, then job_ready_o=1.
- Counter wrap:
  - Stimulus: iv=...00000000_FFFFFFFE, blocks=3.
  - Required response: enc_content_o sequence ...FFFFFFFE, ...FFFFFFFF, ...00000000. Upper 96 bits unchanged.
- Zero-length job:
  - Stimulus: blocks=0.
  - Required response: no enc_v_o and no out_v_o; done_o pulses the cycle after acceptance.
- Backpressure:
  - Stimulus: blocks=8, out_yumi_i low for 20 cycles, pt_v_i random.
  - Required response: outstanding never exceeds 2; out_data_o stable while stalled; 8 results in counter order, each equal to pt XOR model keystream.
- Round trip:
  - Stimulus: encrypt 4 random blocks, then run a second job with the same key/iv on the 4 results.
  - Required response: the original plaintext is recovered; enc_decode_o=0 throughout.
- Reset mid-job:
  - Stimulus: assert reset_i after 2 of 5 outputs.
  - Required response: next cycle job_ready_o=1 and out_v_o=0; no done_o; a following 1-block job completes correctly.
